// File: rtl/qsort_pkg.sv
// Shared types and helpers for the quicksort shell: FSM state encoding,
// default widths and the (value, index) ordering key.
package qsort_pkg;

   localparam int NK_DEF = 23;
   localparam int M_DEF  = 8;
   localparam int L_DEF  = 32;
   localparam int K_DEF  = 10;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      POP,
      PART_SCAN,
      PART_FIX,
      OUTPUT
   } qsort_state_e;

   // Total order: signed value first, original index breaks ties.
   function automatic logic key_lt(input logic signed [63:0] a_val,
                                   input logic signed [63:0] b_val,
                                   input logic [15:0]        a_idx,
                                   input logic [15:0]        b_idx);
      return (a_val < b_val) || ((a_val == b_val) && (a_idx < b_idx));
   endfunction

endpackage

// File: rtl/qsort_range_stack.sv
// LIFO of packed (lo,hi) ranges. push2_i stores a_i then b_i, leaving b_i on top.
// top_o is the current top entry, readable in the same cycle pop_i is asserted.
module qsort_range_stack #(
   parameter int S     = 5,
   parameter int DEPTH = 10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push_i,
   input  logic           push2_i,
   input  logic           pop_i,
   input  logic [2*S-1:0] a_i,
   input  logic [2*S-1:0] b_i,
   output logic [2*S-1:0] top_o,
   output logic           empty_o
);
   localparam int PW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [2*S-1:0] mem_q [DEPTH];
   logic [PW-1:0]  sp_q;
   logic [AW-1:0]  wr0_a, wr1_a, rd_a;

   assign wr0_a   = AW'(sp_q);
   assign wr1_a   = AW'(sp_q + 1'b1);
   assign rd_a    = AW'(sp_q - 1'b1);
   assign top_o   = mem_q[rd_a];
   assign empty_o = (sp_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_q <= '0;
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      end else if (push2_i) begin
         mem_q[wr0_a] <= a_i;
         mem_q[wr1_a] <= b_i;
         sp_q         <= sp_q + PW'(2);
      end else if (push_i) begin
         mem_q[wr0_a] <= a_i;
         sp_q         <= sp_q + 1'b1;
      end else if (pop_i) begin
         sp_q <= sp_q - 1'b1;
      end
   end

endmodule

// File: rtl/quicksort_shell.sv
// Frame quicksort: serial load, iterative Lomuto partition over a LIFO range stack, serial output.
// Define QSORT_VALID_PORT_EN to add the out_valid output.
module quicksort_shell
   import qsort_pkg::*;
#(
   parameter int  Nk = NK_DEF,
   parameter int  M  = M_DEF,
   parameter int  L  = L_DEF,
   parameter int  K  = K_DEF,
   localparam int S  = $clog2(K) + 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [L-1:0]   inp_raw,
   output logic [L-1:0]   out,
   output logic [S*K-1:0] ranger_out
`ifdef QSORT_VALID_PORT_EN
   ,
   output logic           out_valid
`endif
);
   localparam int           AW   = $clog2(K);
   localparam logic [S-1:0] LAST = S'(K - 1);

   if (L != Nk + M + 1) begin : g_bad_width
      $error("quicksort_shell: L must equal Nk+M+1");
   end
   if (K < 2) begin : g_bad_k
      $error("quicksort_shell: K must be at least 2");
   end

   qsort_state_e   state_q;
   logic [S-1:0]   cnt_q, lo_q, hi_q, i_q, j_q;
   logic [L-1:0]   buf_q [K];
   logic [S-1:0]   idx_q [K];
   logic [L-1:0]   out_q;
   logic [S*K-1:0] ranger_q, ranger_d;
`ifdef QSORT_VALID_PORT_EN
   logic           valid_q;
`endif

   logic [AW-1:0]  cnt_a, i_a, j_a, hi_a;
   logic           scan_lt;
   logic           stk_push, stk_push2, stk_pop, stk_empty;
   logic [2*S-1:0] stk_a, stk_b, stk_top;
   logic [S-1:0]   top_lo, top_hi;

   // Range bounds are always below K, so dropping the top index bit is lossless.
   assign cnt_a  = AW'(cnt_q);
   assign i_a    = AW'(i_q);
   assign j_a    = AW'(j_q);
   assign hi_a   = AW'(hi_q);
   assign top_lo = stk_top[2*S-1:S];
   assign top_hi = stk_top[S-1:0];

   assign scan_lt = key_lt(64'($signed(buf_q[j_a])), 64'($signed(buf_q[hi_a])),
                           16'(idx_q[j_a]), 16'(idx_q[hi_a]));

   always_comb begin
      ranger_d = '0;
      for (int k = 0; k < K; k++) ranger_d[S*k +: S] = idx_q[k];
   end

   // Right range pushed first so the left range (lo, i-1) is popped first.
   always_comb begin
      stk_push  = 1'b0;
      stk_push2 = 1'b0;
      stk_pop   = 1'b0;
      stk_a     = '0;
      stk_b     = '0;
      case (state_q)
         LOAD: begin
            stk_push = (cnt_q == LAST);
            stk_a    = {S'(0), LAST};
         end
         POP:      stk_pop = !stk_empty;
         PART_FIX: begin
            stk_push2 = 1'b1;
            stk_a     = {i_q + 1'b1, hi_q};
            stk_b     = {lo_q, i_q - 1'b1};
         end
         default: ;
      endcase
   end

   qsort_range_stack #(.S(S), .DEPTH(K)) u_stack (
      .clk     (clk),
      .rst     (reset),
      .push_i  (stk_push),
      .push2_i (stk_push2),
      .pop_i   (stk_pop),
      .a_i     (stk_a),
      .b_i     (stk_b),
      .top_o   (stk_top),
      .empty_o (stk_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         i_q      <= '0;
         j_q      <= '0;
         out_q    <= '0;
         ranger_q <= '0;
`ifdef QSORT_VALID_PORT_EN
         valid_q  <= 1'b0;
`endif
         for (int k = 0; k < K; k++) begin
            buf_q[k] <= '0;
            idx_q[k] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               out_q <= '0;
`ifdef QSORT_VALID_PORT_EN
               valid_q <= 1'b0;
`endif
               if (start) begin
                  ranger_q <= '0;
                  cnt_q    <= '0;
                  state_q  <= LOAD;
               end
            end
            LOAD: begin
               buf_q[cnt_a] <= inp_raw;
               idx_q[cnt_a] <= cnt_q;
               if (cnt_q == LAST) begin
                  cnt_q   <= '0;
                  state_q <= POP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            POP: begin
               if (stk_empty) begin
                  ranger_q <= ranger_d;
                  cnt_q    <= '0;
                  state_q  <= OUTPUT;
               end else begin
                  lo_q <= top_lo;
                  hi_q <= top_hi;
                  i_q  <= top_lo;
                  j_q  <= top_lo;
                  // hi may be -1 (pushed as i-1 with i=0), hence the signed test.
                  if ($signed(top_lo) < $signed(top_hi)) state_q <= PART_SCAN;
               end
            end
            PART_SCAN: begin
               if (scan_lt) begin
                  buf_q[i_a] <= buf_q[j_a];
                  buf_q[j_a] <= buf_q[i_a];
                  idx_q[i_a] <= idx_q[j_a];
                  idx_q[j_a] <= idx_q[i_a];
                  i_q        <= i_q + 1'b1;
               end
               j_q <= j_q + 1'b1;
               if (j_q == hi_q - 1'b1) state_q <= PART_FIX;
            end
            PART_FIX: begin
               buf_q[i_a]  <= buf_q[hi_a];
               buf_q[hi_a] <= buf_q[i_a];
               idx_q[i_a]  <= idx_q[hi_a];
               idx_q[hi_a] <= idx_q[i_a];
               state_q     <= POP;
            end
            OUTPUT: begin
               out_q <= buf_q[cnt_a];
`ifdef QSORT_VALID_PORT_EN
               valid_q <= 1'b1;
`endif
               if (cnt_q == LAST) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out        = out_q;
   assign ranger_out = ranger_q;
`ifdef QSORT_VALID_PORT_EN
   assign out_valid  = valid_q;
`endif

endmodule

// File: tb/tb_quicksort_shell.sv
// Bench for quicksort_shell: directed and random frames against a sort/latency reference model.
module tb_quicksort_shell;
   localparam int L = 32;
   localparam int K = 10;
   localparam int S = $clog2(K) + 1;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [L-1:0]   inp_raw;
   logic [L-1:0]   out;
   logic [S*K-1:0] ranger_out;
`ifdef QSORT_VALID_PORT_EN
   logic           out_valid;
`endif

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   quicksort_shell dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .inp_raw    (inp_raw),
      .out        (out),
      .ranger_out (ranger_out)
`ifdef QSORT_VALID_PORT_EN
      ,
      .out_valid  (out_valid)
`endif
   );

   // ---------------- scoreboard ----------------
   int           n_checks = 0;
   int           n_pass   = 0;
   logic [L-1:0] exp_q[$];
   logic [L-1:0] frame[K];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // ---------------- reference model ----------------
   // Stable insertion sort on signed value: equal values keep original index order.
   task automatic ref_sort(output int perm[K]);
      int p, b;
      for (int k = 0; k < K; k++) perm[k] = k;
      for (int a = 1; a < K; a++) begin
         p = perm[a];
         b = a;
         while (b > 0 && $signed(frame[perm[b-1]]) > $signed(frame[p])) begin
            perm[b] = perm[b-1];
            b--;
         end
         perm[b] = p;
      end
   endtask

   // Cycles from the last load edge until OUTPUT is entered: one per pop attempt
   // (including the final empty one), one per scan compare, one for the pivot fix.
   function automatic int ref_cycles();
      logic signed [L-1:0] v[K];
      logic signed [L-1:0] tv;
      int id[K];
      int lo_s[$], hi_s[$];
      int cyc = 0, lo, hi, i, ti;
      bit done = 0;
      for (int k = 0; k < K; k++) begin
         v[k]  = frame[k];
         id[k] = k;
      end
      lo_s.push_back(0);
      hi_s.push_back(K - 1);
      while (!done) begin
         cyc++;
         if (lo_s.size() == 0) begin
            done = 1;
         end else begin
            lo = lo_s.pop_back();
            hi = hi_s.pop_back();
            if (lo < hi) begin
               i = lo;
               for (int j = lo; j < hi; j++) begin
                  if (v[j] < v[hi] || (v[j] == v[hi] && id[j] < id[hi])) begin
                     tv = v[j]; v[j] = v[i]; v[i] = tv;
                     ti = id[j]; id[j] = id[i]; id[i] = ti;
                     i++;
                  end
               end
               tv = v[hi]; v[hi] = v[i]; v[i] = tv;
               ti = id[hi]; id[hi] = id[i]; id[i] = ti;
               cyc += hi - lo + 1;
               lo_s.push_back(i + 1); hi_s.push_back(hi);
               lo_s.push_back(lo);    hi_s.push_back(i - 1);
            end
         end
      end
      return cyc;
   endfunction

   function automatic logic [S*K-1:0] pack_perm(input int perm[K]);
      logic [S*K-1:0] r = '0;
      for (int k = 0; k < K; k++) r[S*k +: S] = S'(perm[k]);
      return r;
   endfunction

   // ---------------- driver ----------------
   task automatic run_frame(input string name, input int pulse_at);
      int             perm[K];
      int             t_sort;
      logic [S*K-1:0] exp_r;
      ref_sort(perm);
      exp_r  = pack_perm(perm);
      t_sort = ref_cycles();
      exp_q.delete();
      for (int k = 0; k < K; k++) exp_q.push_back(frame[perm[k]]);

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < K; k++) begin
         inp_raw = frame[k];
         @(negedge clk);
      end
      inp_raw = $urandom;
      for (int t = 0; t < t_sort; t++) begin
         start = (t == pulse_at);
         @(negedge clk);
      end
      start = 1'b0;
      check({name, "/pre_out"}, 64'(out), 64'(0));
      check({name, "/ranger"}, 64'(ranger_out), 64'(exp_r));
      for (int k = 0; k < K; k++) begin
         @(negedge clk);
         check($sformatf("%s/w%0d", name, k), 64'(out), 64'(exp_q.pop_front()));
`ifdef QSORT_VALID_PORT_EN
         check($sformatf("%s/v%0d", name, k), 64'(out_valid), 64'(1));
`endif
      end
      @(negedge clk);
      check({name, "/post_out"}, 64'(out), 64'(0));
`ifdef QSORT_VALID_PORT_EN
      check({name, "/post_valid"}, 64'(out_valid), 64'(0));
`endif
   endtask

   // ---------------- stimulus ----------------
   logic [L-1:0]   spec_vec[K] = '{32'h03400000, 32'hACCCCCD0, 32'hF57E80C8, 32'hF6000000,
                                   32'h00000000, 32'h00000000, 32'h06000000, 32'hFF800000,
                                   32'h06800000, 32'hFB000000};
   int             spec_perm[K] = '{1, 2, 3, 9, 7, 4, 5, 0, 6, 8};
   logic [L-1:0]   tie_set[5] = '{32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000005};
   int             id_perm[K];
   int             rev_perm[K];

   initial begin
      for (int k = 0; k < K; k++) begin
         id_perm[k]  = k;
         rev_perm[k] = K - 1 - k;
      end
      reset   = 1'b1;
      start   = 1'b0;
      inp_raw = '0;
      repeat (3) @(negedge clk);
      check("reset/out", 64'(out), 64'(0));
      check("reset/ranger", 64'(ranger_out), 64'(0));
      reset = 1'b0;
      for (int n = 0; n < 4; n++) begin
         repeat (5) @(negedge clk);
         check($sformatf("idle%0d/out", n), 64'(out), 64'(0));
         check($sformatf("idle%0d/ranger", n), 64'(ranger_out), 64'(0));
      end

      for (int k = 0; k < K; k++) frame[k] = spec_vec[k];
      run_frame("spec", -1);
      check("spec/ranger_const", 64'(ranger_out), 64'(pack_perm(spec_perm)));

      run_frame("spec_pulse", 2);
      check("spec_pulse/ranger_const", 64'(ranger_out), 64'(pack_perm(spec_perm)));

      for (int k = 0; k < K; k++) frame[k] = 32'h80000000 + 32'(k) * 32'h10000000;
      run_frame("ascend", -1);
      check("ascend/identity", 64'(ranger_out), 64'(pack_perm(id_perm)));

      for (int k = 0; k < K; k++) frame[k] = 32'(5 - k) << 20;
      run_frame("descend", -1);
      check("descend/reversed", 64'(ranger_out), 64'(pack_perm(rev_perm)));

      for (int k = 0; k < K; k++) frame[k] = 32'hFF800000;
      run_frame("equal", -1);
      check("equal/identity", 64'(ranger_out), 64'(pack_perm(id_perm)));

      // Abort a frame mid-load with an asynchronous reset.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      inp_raw = 32'h40D00000;
      @(negedge clk);
      inp_raw = 32'h03266666;
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check("abort/ranger", 64'(ranger_out), 64'(0));
      check("abort/out", 64'(out), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < K; k++) frame[k] = spec_vec[(k + 3) % K];
      run_frame("after_abort", -1);

      for (int f = 0; f < 6; f++) begin
         for (int k = 0; k < K; k++)
            frame[k] = (f % 2 == 0) ? 32'($urandom) : tie_set[$urandom_range(0, 4)];
         run_frame($sformatf("rand%0d", f), (f == 3) ? 4 : -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
